// File: rtl/timekeeping_ctrl.sv
// timekeeping_ctrl
//   Sequencer for the second/minute/hour/day/month/year counter chain.
//   In RUN it issues the per-second step and the ripple carries. The day
//   field wraps by load, using a days-in-month value that accounts for leap
//   years. In the ADJ states, button edges step one selected field up or
//   down. A month/year edit clamps the day on the following cycle.
//
// Ports
//   clk_1Hz    system tick clock
//   rst_n      synchronous active-low reset
//   en         run enable (RUN-mode steps only)
//   mode_btn   debounced level, rising edge advances the mode
//   up_btn     debounced level, rising edge = one increment
//   down_btn   debounced level, rising edge = one decrement
//   sec_bin .. year_bin   current field values from the counters
//   adjust     high in any ADJ state
//   sel        one-hot selected field {year,month,day,hour,min,sec}, 0 in RUN
//   inc/dec    per-field step commands, same bit order as sel
//   day_load   load the day counter with day_val
//   day_val    day load value
//   dim        days in the current month/year
//
// State table
//   state    | meaning
//   RUN      | normal timekeeping, carries issued while en=1
//   ADJ_SEC  | up/down steps the second field
//   ADJ_MIN  | up/down steps the minute field
//   ADJ_HOUR | up/down steps the hour field
//   ADJ_DAY  | up/down steps the day field (wraps by load)
//   ADJ_MON  | up/down steps the month field, day clamped afterwards
//   ADJ_YEAR | up/down steps the year field, day clamped afterwards

module timekeeping_ctrl #(
    parameter int TIMEOUT  = 30,
    parameter int YEAR_MAX = 9999
) (
    input  logic        clk_1Hz,
    input  logic        rst_n,
    input  logic        en,
    input  logic        mode_btn,
    input  logic        up_btn,
    input  logic        down_btn,
    input  logic [5:0]  sec_bin,
    input  logic [5:0]  min_bin,
    input  logic [4:0]  hour_bin,
    input  logic [4:0]  day_bin,
    input  logic [3:0]  month_bin,
    input  logic [13:0] year_bin,
    output logic        adjust,
    output logic [5:0]  sel,
    output logic [5:0]  inc,
    output logic [5:0]  dec,
    output logic        day_load,
    output logic [4:0]  day_val,
    output logic [4:0]  dim
);

    localparam int TW = $clog2(TIMEOUT + 1);

    // The year port is 14 bits wide and the idle counter needs a terminal
    // value of at least 1.
    if (YEAR_MAX > 16383 || TIMEOUT < 2) begin : g_param_check
        $error("timekeeping_ctrl: YEAR_MAX must fit in 14 bits and TIMEOUT must be >= 2");
    end

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        ADJ_SEC  = 3'd1,
        ADJ_MIN  = 3'd2,
        ADJ_HOUR = 3'd3,
        ADJ_DAY  = 3'd4,
        ADJ_MON  = 3'd5,
        ADJ_YEAR = 3'd6
    } state_t;

    state_t        state, state_nxt;
    logic          mode_q, up_q, down_q;
    logic [TW-1:0] cnt, cnt_nxt;
    logic          clamp_pend, clamp_nxt;

    logic mode_edge, up_edge, down_edge, any_edge;
    logic step_up, step_dn;
    logic leap;
    logic c_sec, c_min, c_hour, day_wrap;

    assign mode_edge = mode_btn & ~mode_q;
    assign up_edge   = up_btn & ~up_q;
    assign down_edge = down_btn & ~down_q;
    assign any_edge  = mode_edge | up_edge | down_edge;

    // Simultaneous up and down cancel each other; a mode edge swallows any step.
    assign step_up = up_edge & ~down_edge & ~mode_edge;
    assign step_dn = down_edge & ~up_edge & ~mode_edge;

    assign adjust = (state != RUN);

    always_comb begin
        leap = ((year_bin[1:0] == 2'd0) && ((year_bin % 14'd100) != 14'd0))
               || ((year_bin % 14'd400) == 14'd0);
        case (month_bin)
            4'd2:                     dim = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:  dim = 5'd30;
            default:                  dim = 5'd31;
        endcase
    end

    always_comb begin
        sel = 6'b000000;
        case (state)
            ADJ_SEC:  sel = 6'b000001;
            ADJ_MIN:  sel = 6'b000010;
            ADJ_HOUR: sel = 6'b000100;
            ADJ_DAY:  sel = 6'b001000;
            ADJ_MON:  sel = 6'b010000;
            ADJ_YEAR: sel = 6'b100000;
            default:  sel = 6'b000000;
        endcase
    end

    assign c_sec    = (sec_bin == 6'd59);
    assign c_min    = c_sec & (min_bin == 6'd59);
    assign c_hour   = c_min & (hour_bin == 5'd23);
    assign day_wrap = c_hour & (day_bin == dim);

    always_comb begin
        inc      = 6'b000000;
        dec      = 6'b000000;
        day_load = 1'b0;
        day_val  = 5'd0;

        if (state == RUN) begin
            if (en) begin
                inc[0] = 1'b1;
                inc[1] = c_sec;
                inc[2] = c_min;
                inc[3] = c_hour & ~day_wrap;
                inc[4] = day_wrap;
                inc[5] = day_wrap & (month_bin == 4'd12);
                if (day_wrap) begin
                    day_load = 1'b1;
                    day_val  = 5'd1;
                end
            end
        end else if (state == ADJ_DAY) begin
            if (step_up) begin
                if (day_bin == dim) begin
                    day_load = 1'b1;
                    day_val  = 5'd1;
                end else begin
                    inc[3] = 1'b1;
                end
            end
            if (step_dn) begin
                if (day_bin == 5'd1) begin
                    day_load = 1'b1;
                    day_val  = dim;
                end else begin
                    dec[3] = 1'b1;
                end
            end
        end else begin
            if (step_up) inc = sel;
            if (step_dn) dec = sel;
        end

        // Clamp one cycle after a month/year step, once the new month is visible.
        if (clamp_pend && (day_bin > dim)) begin
            inc[3]   = 1'b0;
            dec[3]   = 1'b0;
            day_load = 1'b1;
            day_val  = dim;
        end

        if (!rst_n) begin
            inc      = 6'b000000;
            dec      = 6'b000000;
            day_load = 1'b0;
            day_val  = 5'd0;
        end
    end

    assign clamp_nxt = inc[4] | inc[5] | dec[4] | dec[5];

    always_comb begin
        state_nxt = state;
        if (mode_edge) begin
            case (state)
                RUN:      state_nxt = ADJ_SEC;
                ADJ_SEC:  state_nxt = ADJ_MIN;
                ADJ_MIN:  state_nxt = ADJ_HOUR;
                ADJ_HOUR: state_nxt = ADJ_DAY;
                ADJ_DAY:  state_nxt = ADJ_MON;
                ADJ_MON:  state_nxt = ADJ_YEAR;
                default:  state_nxt = RUN;
            endcase
        end else if ((state != RUN) && !any_edge && (cnt == TW'(TIMEOUT - 1))) begin
            state_nxt = RUN;
        end

        if ((state_nxt == RUN) || (state_nxt != state) || any_edge) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + TW'(1);
        end
    end

    always_ff @(posedge clk_1Hz) begin
        if (!rst_n) begin
            state      <= RUN;
            mode_q     <= 1'b0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
            cnt        <= '0;
            clamp_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            mode_q     <= mode_btn;
            up_q       <= up_btn;
            down_q     <= down_btn;
            cnt        <= cnt_nxt;
            clamp_pend <= clamp_nxt;
        end
    end

endmodule

// File: tb/tb_timekeeping_ctrl.sv
// Scoreboard bench for timekeeping_ctrl: stimulus pushes the expected
// per-cycle outputs, a monitor on the falling edge pops and compares.

module tb_timekeeping_ctrl;

    localparam int T = 30;

    logic        clk_1Hz = 1'b0;
    logic        rst_n, en, mode_btn, up_btn, down_btn;
    logic [5:0]  sec_bin, min_bin;
    logic [4:0]  hour_bin, day_bin;
    logic [3:0]  month_bin;
    logic [13:0] year_bin;
    logic        adjust, day_load;
    logic [5:0]  sel, inc, dec;
    logic [4:0]  day_val, dim;

    timekeeping_ctrl #(.TIMEOUT(T), .YEAR_MAX(9999)) dut (
        .clk_1Hz  (clk_1Hz),
        .rst_n    (rst_n),
        .en       (en),
        .mode_btn (mode_btn),
        .up_btn   (up_btn),
        .down_btn (down_btn),
        .sec_bin  (sec_bin),
        .min_bin  (min_bin),
        .hour_bin (hour_bin),
        .day_bin  (day_bin),
        .month_bin(month_bin),
        .year_bin (year_bin),
        .adjust   (adjust),
        .sel      (sel),
        .inc      (inc),
        .dec      (dec),
        .day_load (day_load),
        .day_val  (day_val),
        .dim      (dim)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    typedef struct {
        string      name;
        logic       adj;
        logic [5:0] sel;
        logic [5:0] inc;
        logic [5:0] dec;
        logic       dl;
        logic [4:0] dv;
        logic [4:0] dim;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_cur;
    int   checks   = 0;
    int   failures = 0;
    logic ok;

    always @(negedge clk_1Hz) begin
        if (exp_q.size() > 0) begin
            e_cur = exp_q.pop_front();
            ok = (adjust === e_cur.adj) && (sel === e_cur.sel) && (inc === e_cur.inc)
                 && (dec === e_cur.dec) && (day_load === e_cur.dl) && (dim === e_cur.dim)
                 && (!e_cur.dl || (day_val === e_cur.dv));
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s: got adj=%b sel=%b inc=%b dec=%b dl=%b dv=%0d dim=%0d, want adj=%b sel=%b inc=%b dec=%b dl=%b dv=%0d dim=%0d",
                         e_cur.name, adjust, sel, inc, dec, day_load, day_val, dim,
                         e_cur.adj, e_cur.sel, e_cur.inc, e_cur.dec, e_cur.dl, e_cur.dv, e_cur.dim);
            end
        end
    end

    task automatic tick();
        @(posedge clk_1Hz);
        #1;
    endtask

    task automatic expect_out(input string name, input logic adj, input logic [5:0] s,
                              input logic [5:0] i, input logic [5:0] d, input logic dl,
                              input logic [4:0] dv, input logic [4:0] dm);
        exp_t e;
        e.name = name; e.adj = adj; e.sel = s; e.inc = i; e.dec = d;
        e.dl = dl; e.dv = dv; e.dim = dm;
        exp_q.push_back(e);
    endtask

    task automatic fields(input int s, input int mi, input int h, input int d,
                          input int mo, input int y);
        sec_bin   = 6'(s);
        min_bin   = 6'(mi);
        hour_bin  = 5'(h);
        day_bin   = 5'(d);
        month_bin = 4'(mo);
        year_bin  = 14'(y);
    endtask

    // One mode press spread over two cycles (rise, then release).
    task automatic mode_press();
        mode_btn = 1'b1; tick();
        mode_btn = 1'b0; tick();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; mode_btn = 1'b0; up_btn = 1'b0; down_btn = 1'b0;
        fields(59, 59, 23, 31, 12, 2023);
        tick(); tick();

        // RUN carry chain and leap years
        expect_out("rst_cmds", 0, 6'b000000, 6'b000000, 6'b000000, 0, 0, 31); tick();
        rst_n = 1'b1;
        expect_out("run_newyear", 0, 6'b000000, 6'b110111, 6'b000000, 1, 1, 31); tick();
        fields(59, 59, 23, 28, 2, 2024);
        expect_out("run_leap2024", 0, 6'b000000, 6'b001111, 6'b000000, 0, 0, 29); tick();
        year_bin = 14'd2100;
        expect_out("run_2100", 0, 6'b000000, 6'b010111, 6'b000000, 1, 1, 28); tick();
        year_bin = 14'd2000;
        expect_out("run_2000", 0, 6'b000000, 6'b001111, 6'b000000, 0, 0, 29); tick();
        en = 1'b0;
        expect_out("run_en_off", 0, 6'b000000, 6'b000000, 6'b000000, 0, 0, 29); tick();
        en = 1'b1; fields(30, 20, 10, 15, 6, 2023);
        expect_out("run_plain", 0, 6'b000000, 6'b000001, 6'b000000, 0, 0, 30); tick();
        sec_bin = 6'd59;
        expect_out("run_sec59", 0, 6'b000000, 6'b000011, 6'b000000, 0, 0, 30); tick();

        // Mode walk to ADJ_DAY, day wrap by load
        en = 1'b0; fields(30, 20, 10, 1, 6, 2023);
        mode_btn = 1'b1;
        expect_out("mode_from_run", 0, 6'b000000, 6'b000000, 6'b000000, 0, 0, 30); tick();
        mode_btn = 1'b0;
        expect_out("sel_sec", 1, 6'b000001, 6'b000000, 6'b000000, 0, 0, 30); tick();
        mode_btn = 1'b1; tick(); mode_btn = 1'b0;
        expect_out("sel_min", 1, 6'b000010, 6'b000000, 6'b000000, 0, 0, 30); tick();
        mode_btn = 1'b1; tick(); mode_btn = 1'b0;
        expect_out("sel_hour", 1, 6'b000100, 6'b000000, 6'b000000, 0, 0, 30); tick();
        mode_btn = 1'b1; tick(); mode_btn = 1'b0;
        expect_out("sel_day", 1, 6'b001000, 6'b000000, 6'b000000, 0, 0, 30); tick();
        down_btn = 1'b1;
        expect_out("day_down_wrap", 1, 6'b001000, 6'b000000, 6'b000000, 1, 30, 30); tick();
        down_btn = 1'b0;
        expect_out("day_idle", 1, 6'b001000, 6'b000000, 6'b000000, 0, 0, 30); tick();
        up_btn = 1'b1; day_bin = 5'd30;
        expect_out("day_up_wrap", 1, 6'b001000, 6'b000000, 6'b000000, 1, 1, 30); tick();
        up_btn = 1'b0; tick();
        up_btn = 1'b1; day_bin = 5'd15;
        expect_out("day_up", 1, 6'b001000, 6'b001000, 6'b000000, 0, 0, 30); tick();
        up_btn = 1'b0;

        // Month and year edits followed by a clamp
        mode_btn = 1'b1; tick(); mode_btn = 1'b0;
        fields(30, 20, 10, 31, 1, 2023);
        expect_out("sel_mon", 1, 6'b010000, 6'b000000, 6'b000000, 0, 0, 31); tick();
        up_btn = 1'b1;
        expect_out("mon_up", 1, 6'b010000, 6'b010000, 6'b000000, 0, 0, 31); tick();
        up_btn = 1'b0; month_bin = 4'd2;
        expect_out("mon_clamp", 1, 6'b010000, 6'b000000, 6'b000000, 1, 28, 28); tick();
        day_bin = 5'd28;
        expect_out("mon_clamp_done", 1, 6'b010000, 6'b000000, 6'b000000, 0, 0, 28); tick();
        mode_btn = 1'b1; tick(); mode_btn = 1'b0;
        fields(30, 20, 10, 29, 2, 2024);
        expect_out("sel_year", 1, 6'b100000, 6'b000000, 6'b000000, 0, 0, 29); tick();
        down_btn = 1'b1;
        expect_out("year_down", 1, 6'b100000, 6'b000000, 6'b100000, 0, 0, 29); tick();
        down_btn = 1'b0; year_bin = 14'd2023;
        expect_out("year_clamp", 1, 6'b100000, 6'b000000, 6'b000000, 1, 28, 28); tick();
        day_bin = 5'd28; mode_btn = 1'b1;
        expect_out("year_exit", 1, 6'b100000, 6'b000000, 6'b000000, 0, 0, 28); tick();
        mode_btn = 1'b0;
        expect_out("back_run", 0, 6'b000000, 6'b000000, 6'b000000, 0, 0, 28); tick();

        // Idle timeout: plain expiry
        mode_btn = 1'b1; tick();
        for (int k = 0; k <= T; k++) begin
            mode_btn = 1'b0;
            if (k == T - 1)
                expect_out("to_last", 1, 6'b000001, 6'b000000, 6'b000000, 0, 0, 28);
            if (k == T)
                expect_out("to_run", 0, 6'b000000, 6'b000000, 6'b000000, 0, 0, 28);
            tick();
        end

        // Idle timeout restarted by an up edge at T-2
        mode_btn = 1'b1; tick();
        for (int k = 0; k <= 2 * T - 1; k++) begin
            mode_btn = 1'b0;
            up_btn = (k == T - 2);
            if (k == T - 2)
                expect_out("to_up", 1, 6'b000001, 6'b000001, 6'b000000, 0, 0, 28);
            if (k == T)
                expect_out("to_restart", 1, 6'b000001, 6'b000000, 6'b000000, 0, 0, 28);
            if (k == 2 * T - 2)
                expect_out("to_last2", 1, 6'b000001, 6'b000000, 6'b000000, 0, 0, 28);
            if (k == 2 * T - 1)
                expect_out("to_run2", 0, 6'b000000, 6'b000000, 6'b000000, 0, 0, 28);
            tick();
        end
        up_btn = 1'b0;

        // Conflicting buttons in ADJ_HOUR
        mode_press(); mode_press();
        mode_btn = 1'b1; tick(); mode_btn = 1'b0;
        expect_out("sel_hour2", 1, 6'b000100, 6'b000000, 6'b000000, 0, 0, 28); tick();
        up_btn = 1'b1; down_btn = 1'b1;
        expect_out("hour_updown", 1, 6'b000100, 6'b000000, 6'b000000, 0, 0, 28); tick();
        up_btn = 1'b0; down_btn = 1'b0; tick();
        up_btn = 1'b1;
        expect_out("hour_up", 1, 6'b000100, 6'b000100, 6'b000000, 0, 0, 28); tick();
        up_btn = 1'b0; tick();
        mode_btn = 1'b1; up_btn = 1'b1;
        expect_out("hour_mode_up", 1, 6'b000100, 6'b000000, 6'b000000, 0, 0, 28); tick();
        mode_btn = 1'b0; up_btn = 1'b0;
        expect_out("after_mode_up", 1, 6'b001000, 6'b000000, 6'b000000, 0, 0, 28); tick();

        // Reset with a clamp pending discards it
        mode_btn = 1'b1; tick(); mode_btn = 1'b0;
        fields(30, 20, 10, 31, 1, 2023); tick();
        up_btn = 1'b1;
        expect_out("mon_up2", 1, 6'b010000, 6'b010000, 6'b000000, 0, 0, 31); tick();
        up_btn = 1'b0; rst_n = 1'b0; month_bin = 4'd2; tick();
        rst_n = 1'b1;
        expect_out("post_rst", 0, 6'b000000, 6'b000000, 6'b000000, 0, 0, 28); tick();

        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
